// File: rtl/ahb_lite_pkg.sv
// ---------------------------------------------------------------------------
// ahb_lite_pkg
// Shared AHB-Lite encodings and the response record used by the command
// master, its response FIFO and the slave-side checkers.
//   HTRANS_IDLE / HTRANS_NONSEQ : the only transfer types this master issues
//   HSIZE_WORD                  : every transfer is a 32-bit word
//   HRESP_OKAY / HRESP_ERROR    : slave response encodings
//   ahb_rsp_t                   : {write, rdata, error} for one completed transfer
// ---------------------------------------------------------------------------
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  typedef struct packed {
    logic        write;
    logic [31:0] rdata;
    logic        error;
  } ahb_rsp_t;

endpackage

// File: rtl/ahb_rsp_fifo.sv
// ---------------------------------------------------------------------------
// ahb_rsp_fifo
// Small circular FIFO holding completed-transfer responses until the
// consumer takes them. DEPTH must be a power of two so the pointers wrap
// naturally. The head entry reads as all-zero while the FIFO is empty.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   push_i, wdata_i: write one response (caller guarantees room)
//   pop_i          : consume the head entry (ignored when empty)
//   valid_o        : FIFO not empty
//   rdata_o        : head entry
// ---------------------------------------------------------------------------
module ahb_rsp_fifo
  import ahb_lite_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  ahb_rsp_t wdata_i,
  input  logic     pop_i,
  output logic     valid_o,
  output ahb_rsp_t rdata_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ahb_rsp_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_pop;

  assign valid_o = (count_q != '0);
  assign do_pop  = pop_i && valid_o;
  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;

  // Pointer and occupancy bookkeeping; a push and pop on the same edge
  // leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push_i, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset empties the FIFO so stale entries vanish.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/ahb_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// ahb_lite_cmd_master
// AHB-Lite initiator turning a valid/ready command stream into single-word
// transfers, overlapping the address phase of the next transfer with the
// data phase of the current one. Completed transfers come back in issue
// order on a buffered valid/ready response stream.
//   HCLK, HRESETn          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    : command handshake
//   cmd_write/addr/wdata   : command fields
//   rsp_valid/rsp_ready    : response handshake
//   rsp_write/rdata/error  : response fields (rdata is 0 for writes)
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA : AHB-Lite master outputs
//   HREADY/HRESP/HRDATA    : AHB-Lite slave-side inputs
// ---------------------------------------------------------------------------
module ahb_lite_cmd_master
  import ahb_lite_pkg::*;
#(
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA
);

  localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;

  // Address phase registers
  logic          addr_v_q,     addr_v_d;
  logic [31:0]   haddr_q,      haddr_d;
  logic          hwrite_q,     hwrite_d;
  logic [31:0]   addr_wdata_q, addr_wdata_d;
  // Data phase registers
  logic          data_v_q,     data_v_d;
  logic          data_write_q, data_write_d;
  logic [31:0]   hwdata_q,     hwdata_d;
  // Accepted-but-not-popped transfers
  logic [CW-1:0] in_flight_q,  in_flight_d;

  logic          accept;
  logic          addr_done;
  logic          data_done;
  logic          pop;
  ahb_rsp_t      push_rsp;
  ahb_rsp_t      head_rsp;

  // Capping in_flight at RSP_DEPTH reserves a FIFO slot for every transfer
  // on the bus, so a completing data phase can always be pushed.
  assign cmd_ready = (in_flight_q < CW'(RSP_DEPTH)) && (!addr_v_q || HREADY);
  assign accept    = cmd_valid && cmd_ready;
  assign addr_done = addr_v_q && HREADY;
  assign data_done = data_v_q && HREADY;
  assign pop       = rsp_valid && rsp_ready;

  assign HADDR  = haddr_q;
  assign HTRANS = addr_v_q ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE = hwrite_q;
  assign HSIZE  = HSIZE_WORD;
  assign HWDATA = hwdata_q;

  assign push_rsp = '{write: data_write_q,
                      rdata: data_write_q ? 32'h0 : HRDATA,
                      error: HRESP};

  // Pipeline advance: one HREADY edge ends the data phase and moves the
  // address phase into it. HWDATA only changes when a write enters the
  // data phase, so it stays put through wait states and during reads.
  always_comb begin
    addr_v_d     = addr_v_q;
    haddr_d      = haddr_q;
    hwrite_d     = hwrite_q;
    addr_wdata_d = addr_wdata_q;
    data_v_d     = data_v_q;
    data_write_d = data_write_q;
    hwdata_d     = hwdata_q;
    in_flight_d  = in_flight_q;

    if (HREADY) begin
      data_v_d = addr_v_q;
    end
    if (addr_done) begin
      addr_v_d     = 1'b0;
      data_write_d = hwrite_q;
      if (hwrite_q) begin
        hwdata_d = addr_wdata_q;
      end
    end
    if (accept) begin
      addr_v_d     = 1'b1;
      haddr_d      = cmd_addr & ~32'h3;
      hwrite_d     = cmd_write;
      addr_wdata_d = cmd_wdata;
    end

    unique case ({accept, pop})
      2'b10:   in_flight_d = in_flight_q + CW'(1);
      2'b01:   in_flight_d = in_flight_q - CW'(1);
      default: in_flight_d = in_flight_q;
    endcase
  end

  // State register; reset drops every transfer in flight.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_v_q     <= 1'b0;
      haddr_q      <= '0;
      hwrite_q     <= 1'b0;
      addr_wdata_q <= '0;
      data_v_q     <= 1'b0;
      data_write_q <= 1'b0;
      hwdata_q     <= '0;
      in_flight_q  <= '0;
    end else begin
      addr_v_q     <= addr_v_d;
      haddr_q      <= haddr_d;
      hwrite_q     <= hwrite_d;
      addr_wdata_q <= addr_wdata_d;
      data_v_q     <= data_v_d;
      data_write_q <= data_write_d;
      hwdata_q     <= hwdata_d;
      in_flight_q  <= in_flight_d;
    end
  end

  ahb_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .push_i  (data_done),
    .wdata_i (push_rsp),
    .pop_i   (pop),
    .valid_o (rsp_valid),
    .rdata_o (head_rsp)
  );

  assign rsp_write = head_rsp.write;
  assign rsp_rdata = head_rsp.rdata;
  assign rsp_error = head_rsp.error;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_cmd_master
// Drives the command master against a behavioural AHBGPIO-style slave and
// predicts every response from the register semantics of that slave.
// A second, shallow instance exercises response back-pressure.
// ---------------------------------------------------------------------------
module tb_ahb_lite_cmd_master;
  import ahb_lite_pkg::*;

  localparam int          DEPTH     = 4;
  localparam logic [31:0] DATA_ADDR = 32'h5300_0000;
  localparam logic [31:0] DIR_ADDR  = 32'h5300_0004;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    int          stall;
  } cmd_t;

  logic        HCLK;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE;

  logic        bpCmdValid, bpCmdReady, bpCmdWrite;
  logic [31:0] bpCmdAddr, bpCmdWdata;
  logic        bpRspValid, bpRspReady, bpRspWrite, bpRspError;
  logic [31:0] bpRspRdata, bpHaddr, bpHwdata, bpHrdata;
  logic [1:0]  bpHtrans;
  logic        bpHwrite, bpHready, bpHresp;
  logic [2:0]  bpHsize;

  int total = 0;
  int bad   = 0;

  // Model and slave state
  cmd_t        issueQ[$];
  ahb_rsp_t    expQ[$];
  ahb_rsp_t    rspLog[$];
  logic [15:0] mDir, mOut;
  logic [15:0] gpioDir, gpioOut, gpioIn;
  logic        cmdErr;
  int          cmdStall;
  bit          sActive, sErrFirst;
  cmd_t        sCmd;
  int          sStall;
  logic        nextReady, nextResp;
  logic [31:0] nextRdata;
  bit          prevAddrWait, prevDataWait;
  logic [31:0] prevAddr, prevWdata;
  logic        prevWrite;
  int          accCount, popCount, negCount;
  int          acceptNeg, firstRspNeg;
  int          nonseqRun, maxNonseqRun, rspRun, maxRspRun;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_lite_cmd_master #(.RSP_DEPTH(DEPTH)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  ahb_lite_cmd_master #(.RSP_DEPTH(2)) dutBp (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(bpCmdValid), .cmd_ready(bpCmdReady), .cmd_write(bpCmdWrite),
    .cmd_addr(bpCmdAddr), .cmd_wdata(bpCmdWdata),
    .rsp_valid(bpRspValid), .rsp_ready(bpRspReady), .rsp_write(bpRspWrite),
    .rsp_rdata(bpRspRdata), .rsp_error(bpRspError),
    .HADDR(bpHaddr), .HTRANS(bpHtrans), .HWRITE(bpHwrite), .HSIZE(bpHsize),
    .HWDATA(bpHwdata), .HREADY(bpHready), .HRESP(bpHresp), .HRDATA(bpHrdata)
  );

  // One comparison: counts it, reports a mismatch on a single line.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // GPIO register read: input pins where dir=0, output register where dir=1.
  function automatic logic [31:0] readGpio(input logic [31:0] addr, input logic [15:0] dir,
                                           input logic [15:0] outv, input logic [15:0] inv);
    if ((addr & ~32'h3) == DATA_ADDR) return {16'h0, (inv & ~dir) | (outv & dir)};
    if ((addr & ~32'h3) == DIR_ADDR)  return {16'h0, dir};
    return 32'h0;
  endfunction

  // Single compare/slave process: at each falling edge it checks the DUT
  // against the model, resolves what the next rising edge completes, and
  // then drives the slave outputs just after that rising edge.
  always begin
    @(negedge HCLK);
    negCount++;
    if (!HRESETn) begin
      issueQ.delete();
      expQ.delete();
      sActive = 0; prevAddrWait = 0; prevDataWait = 0;
      mDir = '0; mOut = '0; gpioDir = '0; gpioOut = '0;
      accCount = 0; popCount = 0;
      acceptNeg = -1; firstRspNeg = -1;
      nextReady = 1'b1; nextResp = 1'b0; nextRdata = '0;
    end else begin
      checkOutput("hsize", {29'h0, HSIZE}, {29'h0, HSIZE_WORD});
      checkOutput("htransLegal", {31'h0, (HTRANS == HTRANS_IDLE) || (HTRANS == HTRANS_NONSEQ)}, 32'h1);
      if (prevAddrWait) begin
        checkOutput("htransHold", {30'h0, HTRANS}, {30'h0, HTRANS_NONSEQ});
        checkOutput("haddrHold", HADDR, prevAddr);
        checkOutput("hwriteHold", {31'h0, HWRITE}, {31'h0, prevWrite});
      end
      if (prevDataWait) checkOutput("hwdataHold", HWDATA, prevWdata);

      if (accCount - popCount >= DEPTH) checkOutput("cmdReadyFull", {31'h0, cmd_ready}, 32'h0);
      else if (HREADY) checkOutput("cmdReadyFree", {31'h0, cmd_ready}, 32'h1);

      if (rsp_valid) begin
        if (firstRspNeg < 0) firstRspNeg = negCount;
        rspRun++;
        if (rspRun > maxRspRun) maxRspRun = rspRun;
        if (expQ.size() == 0) begin
          checkOutput("spuriousRsp", {31'h0, rsp_valid}, 32'h0);
        end else begin
          checkOutput("rspWrite", {31'h0, rsp_write}, {31'h0, expQ[0].write});
          checkOutput("rspRdata", rsp_rdata, expQ[0].rdata);
          checkOutput("rspError", {31'h0, rsp_error}, {31'h0, expQ[0].error});
          if (rsp_ready) begin
            void'(expQ.pop_front());
            popCount++;
          end
        end
        if (rsp_ready) rspLog.push_back('{write: rsp_write, rdata: rsp_rdata, error: rsp_error});
      end else begin
        rspRun = 0;
      end

      if (HTRANS == HTRANS_NONSEQ) begin
        nonseqRun++;
        if (nonseqRun > maxNonseqRun) maxNonseqRun = nonseqRun;
      end else begin
        nonseqRun = 0;
      end

      prevAddrWait = (HTRANS == HTRANS_NONSEQ) && !HREADY;
      prevAddr     = HADDR;
      prevWrite    = HWRITE;
      prevDataWait = sActive && sCmd.write && !HREADY;
      prevWdata    = HWDATA;

      if (sActive && HREADY) begin
        if (sCmd.write) begin
          checkOutput("hwdata", HWDATA, sCmd.wdata);
          if (!sCmd.err) begin
            if ((sCmd.addr & ~32'h3) == DIR_ADDR)  gpioDir = HWDATA[15:0];
            if ((sCmd.addr & ~32'h3) == DATA_ADDR) gpioOut = HWDATA[15:0];
          end
        end
        sActive = 0;
      end
      if ((HTRANS == HTRANS_NONSEQ) && HREADY) begin
        if (issueQ.size() == 0) begin
          checkOutput("unexpectedNonseq", {30'h0, HTRANS}, {30'h0, HTRANS_IDLE});
        end else begin
          sCmd = issueQ.pop_front();
          checkOutput("haddr", HADDR, sCmd.addr & ~32'h3);
          checkOutput("hwrite", {31'h0, HWRITE}, {31'h0, sCmd.write});
          sActive = 1; sStall = sCmd.stall; sErrFirst = 0;
        end
      end

      if (cmd_valid && cmd_ready) begin
        cmd_t c;
        ahb_rsp_t r;
        c = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, err: cmdErr, stall: cmdStall};
        issueQ.push_back(c);
        if (c.write) begin
          r = '{write: 1'b1, rdata: 32'h0, error: c.err};
          if (!c.err && ((c.addr & ~32'h3) == DIR_ADDR))  mDir = c.wdata[15:0];
          if (!c.err && ((c.addr & ~32'h3) == DATA_ADDR)) mOut = c.wdata[15:0];
        end else begin
          r = '{write: 1'b0, rdata: readGpio(c.addr, mDir, mOut, gpioIn), error: c.err};
        end
        expQ.push_back(r);
        accCount++;
        if (acceptNeg < 0) acceptNeg = negCount;
      end

      if (sActive) begin
        if (sStall > 0) begin
          nextReady = 1'b0; nextResp = HRESP_OKAY; sStall--;
        end else if (sCmd.err && !sErrFirst) begin
          nextReady = 1'b0; nextResp = HRESP_ERROR; sErrFirst = 1;
        end else begin
          nextReady = 1'b1; nextResp = sCmd.err;
        end
        nextRdata = sCmd.write ? 32'hDEAD_BEEF : readGpio(sCmd.addr, gpioDir, gpioOut, gpioIn);
      end else begin
        nextReady = 1'b1; nextResp = HRESP_OKAY; nextRdata = '0;
      end
    end
    @(posedge HCLK);
    #1;
    HREADY = nextReady;
    HRESP  = nextResp;
    HRDATA = nextRdata;
  end

  // Offer one command and hold it until accepted; returns just after the
  // accepting edge with cmd_valid still high.
  task automatic applyStimulus(input logic write, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic err, input int stall);
    bit taken;
    cmd_valid = 1'b1; cmd_write = write; cmd_addr = addr; cmd_wdata = wdata;
    cmdErr = err; cmdStall = stall;
    taken = 0;
    for (int i = 0; i < 40 && !taken; i++) begin
      @(negedge HCLK);
      if (cmd_ready) taken = 1;
    end
    if (!taken) begin
      checkOutput("acceptTimeout", {31'h0, cmd_ready}, 32'h1);
      cmd_valid = 1'b0;
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic idleAndDrain();
    cmd_valid = 1'b0;
    for (int i = 0; i < 60 && (expQ.size() != 0 || issueQ.size() != 0); i++) @(negedge HCLK);
    checkOutput("drainLeft", expQ.size(), 0);
    repeat (2) @(posedge HCLK);
    #1;
  endtask

  initial begin
    int bpPops;
    HRESETn = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 1;
    cmdErr = 0; cmdStall = 0; gpioIn = 16'h0;
    HREADY = 1; HRESP = 0; HRDATA = 0;
    bpCmdValid = 0; bpCmdWrite = 0; bpCmdAddr = 0; bpCmdWdata = 0; bpRspReady = 1;
    bpHready = 1; bpHresp = 0; bpHrdata = 32'hCAFE_0001;
    nonseqRun = 0; maxNonseqRun = 0; rspRun = 0; maxRspRun = 0; negCount = 0;
    #1 HRESETn = 1'b0;
    #3;
    checkOutput("rstHtrans", {30'h0, HTRANS}, 32'h0);
    checkOutput("rstHaddr", HADDR, 32'h0);
    checkOutput("rstHwrite", {31'h0, HWRITE}, 32'h0);
    checkOutput("rstHwdata", HWDATA, 32'h0);
    checkOutput("rstRspValid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("rstRspFields", {rsp_rdata[29:0], rsp_write, rsp_error}, 32'h0);
    repeat (3) @(posedge HCLK);
    #2 HRESETn = 1'b1;
    @(posedge HCLK); #1;

    $display("[TB] GPIO configuration writes");
    applyStimulus(1, DIR_ADDR, 32'h1, 0, 0);
    applyStimulus(1, DATA_ADDR, 32'h00A5, 0, 0);
    idleAndDrain();
    checkOutput("gpioOutA5", {16'h0, gpioOut}, 32'h00A5);
    checkOutput("latency", firstRspNeg - acceptNeg, 3);
    checkOutput("writeRspCount", rspLog.size(), 2);
    if (rspLog.size() == 2) begin
      checkOutput("writeRsp0", {30'h0, rspLog[0].write, rspLog[0].error}, 32'h2);
      checkOutput("writeRsp1", {30'h0, rspLog[1].write, rspLog[1].error}, 32'h2);
    end

    $display("[TB] GPIO input read");
    rspLog.delete();
    gpioIn = 16'h1234;
    applyStimulus(1, DIR_ADDR, 32'h0, 0, 0);
    applyStimulus(0, DATA_ADDR, 32'h0, 0, 0);
    idleAndDrain();
    checkOutput("readRspCount", rspLog.size(), 2);
    if (rspLog.size() == 2) begin
      checkOutput("readRdata", rspLog[1].rdata, 32'h1234);
      checkOutput("readWrite", {31'h0, rspLog[1].write}, 32'h0);
    end

    $display("[TB] back-to-back burst");
    applyStimulus(1, DIR_ADDR, 32'hFFFF, 0, 0);
    idleAndDrain();
    rspLog.delete();
    maxNonseqRun = 0; maxRspRun = 0;
    applyStimulus(1, DATA_ADDR, 32'h11, 0, 0);
    applyStimulus(0, DATA_ADDR, 32'h0, 0, 0);
    applyStimulus(1, DATA_ADDR, 32'h22, 0, 0);
    applyStimulus(0, DATA_ADDR, 32'h0, 0, 0);
    idleAndDrain();
    checkOutput("burstNonseqRun", {31'h0, maxNonseqRun >= 4}, 32'h1);
    checkOutput("burstRspRun", {31'h0, maxRspRun >= 4}, 32'h1);
    checkOutput("burstRspCount", rspLog.size(), 4);
    if (rspLog.size() == 4) begin
      checkOutput("burstRead1", rspLog[1].rdata, 32'h11);
      checkOutput("burstRead3", rspLog[3].rdata, 32'h22);
    end

    $display("[TB] data-phase wait states");
    rspLog.delete();
    applyStimulus(1, DATA_ADDR, 32'h5A5A, 0, 3);
    applyStimulus(0, DIR_ADDR, 32'h0, 0, 0);
    idleAndDrain();
    checkOutput("stallGpioOut", {16'h0, gpioOut}, 32'h5A5A);
    checkOutput("stallRspCount", rspLog.size(), 2);

    $display("[TB] slave error response");
    rspLog.delete();
    applyStimulus(1, DATA_ADDR, 32'h0F0F, 1, 0);
    applyStimulus(1, DATA_ADDR, 32'h00F0, 0, 0);
    idleAndDrain();
    checkOutput("errRspCount", rspLog.size(), 2);
    if (rspLog.size() == 2) begin
      checkOutput("errFirst", {31'h0, rspLog[0].error}, 32'h1);
      checkOutput("errSecond", {31'h0, rspLog[1].error}, 32'h0);
    end
    checkOutput("errGpioOut", {16'h0, gpioOut}, 32'h00F0);

    $display("[TB] response back-pressure (depth 2)");
    bpPops = 0;
    bpRspReady = 0;
    bpCmdValid = 1; bpCmdWrite = 1; bpCmdAddr = DATA_ADDR; bpCmdWdata = 32'h1;
    @(negedge HCLK); checkOutput("bpReadyCmd0", {31'h0, bpCmdReady}, 32'h1);
    @(posedge HCLK); #1;
    bpCmdWrite = 0; bpCmdAddr = DATA_ADDR; bpCmdWdata = 32'h0;
    @(negedge HCLK); checkOutput("bpReadyCmd1", {31'h0, bpCmdReady}, 32'h1);
    @(posedge HCLK); #1;
    bpCmdWrite = 1; bpCmdAddr = DIR_ADDR; bpCmdWdata = 32'h3;
    @(negedge HCLK);
    checkOutput("bpBlockedCmd2", {31'h0, bpCmdReady}, 32'h0);
    checkOutput("bpHtransCmd1", {30'h0, bpHtrans}, {30'h0, HTRANS_NONSEQ});
    for (int i = 0; i < 3; i++) begin
      @(posedge HCLK); #1;
      @(negedge HCLK);
      checkOutput("bpStillBlocked", {31'h0, bpCmdReady}, 32'h0);
      if (i == 0) checkOutput("bpHtransIdle", {30'h0, bpHtrans}, {30'h0, HTRANS_IDLE});
      if (i == 2) checkOutput("bpRspHeld", {31'h0, bpRspValid}, 32'h1);
    end
    @(posedge HCLK); #1;
    bpRspReady = 1;
    @(negedge HCLK);
    checkOutput("bpBlockedAtPop", {31'h0, bpCmdReady}, 32'h0);
    checkOutput("bpRsp0", {bpRspRdata[29:0], bpRspWrite, bpRspError}, 32'h2);
    if (bpRspValid) bpPops++;
    @(posedge HCLK); #1;
    @(negedge HCLK);
    checkOutput("bpReadyAfterPop", {31'h0, bpCmdReady}, 32'h1);
    checkOutput("bpRsp1Write", {31'h0, bpRspWrite}, 32'h0);
    checkOutput("bpRsp1Rdata", bpRspRdata, 32'hCAFE_0001);
    if (bpRspValid) bpPops++;
    @(posedge HCLK); #1;
    bpCmdValid = 0;
    begin
      bit got;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge HCLK);
        if (bpRspValid) begin
          got = 1;
          bpPops++;
          checkOutput("bpRsp2", {bpRspRdata[29:0], bpRspWrite, bpRspError}, 32'h2);
        end
      end
    end
    checkOutput("bpRspTotal", bpPops, 3);
    @(posedge HCLK); #1;

    $display("[TB] reset during a burst");
    rspLog.delete();
    applyStimulus(1, DATA_ADDR, 32'h1, 0, 0);
    applyStimulus(1, DATA_ADDR, 32'h2, 0, 0);
    #2 HRESETn = 1'b0;
    cmd_valid = 0;
    #1;
    checkOutput("midRstHtrans", {30'h0, HTRANS}, 32'h0);
    checkOutput("midRstRspValid", {31'h0, rsp_valid}, 32'h0);
    repeat (2) @(posedge HCLK);
    #2 HRESETn = 1'b1;
    repeat (8) @(posedge HCLK);
    #1;
    checkOutput("noStaleRsp", rspLog.size(), 0);
    checkOutput("leftoverExp", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
